// File: rtl/dice_pkg.sv
// Shared definitions for the dice roll capture block and the dice generator.
// Holds face limits, counter widths, the FSM state type and a face validity helper.
package dice_pkg;

    localparam int FACE_MIN = 1;
    localparam int FACE_MAX = 6;
    localparam int FACE_W   = 3;
    localparam int COUNT_W  = 8;
    localparam int TOTAL_W  = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        REPORT  = 2'd2
    } dice_state_e;

    // A throw is a real face only inside FACE_MIN..FACE_MAX; 0 and 7 are generator faults.
    function automatic logic face_is_valid(input logic [FACE_W-1:0] face);
        return (int'(face) >= FACE_MIN) && (int'(face) <= FACE_MAX);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter
    import dice_pkg::*;
#(
    parameter int W = COUNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dice_roll_capture.sv
// Captures a dice throw when the roll button is released, presents it with a
// valid/ready handshake and keeps per-face, error and total roll statistics.
//
// state   | meaning
// IDLE    | waiting for the button to be pressed
// ROLLING | button held, generator still tumbling
// REPORT  | result captured and held until accepted downstream
module dice_roll_capture
    import dice_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [FACE_W-1:0]  throw,
    input  logic               res_ready,
    output logic               res_valid,
    output logic [FACE_W-1:0]  res_face,
    output logic               res_error,
    input  logic               count_clr,
    input  logic [2:0]         count_sel,
    output logic [COUNT_W-1:0] count_out,
    output logic [TOTAL_W-1:0] roll_total
);

    dice_state_e         state_q, state_d;
    logic                res_valid_q, res_valid_d;
    logic [FACE_W-1:0]   res_face_q, res_face_d;
    logic                res_error_q, res_error_d;
    logic [TOTAL_W-1:0]  total_q, total_d;

    logic                capture;
    logic                throw_ok;
    logic                cap_valid;
    logic                cap_error;
    logic [COUNT_W-1:0]  face_cnt [FACE_MIN:FACE_MAX];
    logic [COUNT_W-1:0]  err_cnt;

    assign throw_ok = face_is_valid(throw);

    // Throw is frozen once the button is sampled low, so capture needs no settle delay.
    always_comb begin
        state_d     = state_q;
        res_valid_d = res_valid_q;
        res_face_d  = res_face_q;
        res_error_d = res_error_q;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (button) begin
                    state_d = ROLLING;
                end
            end
            ROLLING: begin
                if (!button) begin
                    capture     = 1'b1;
                    state_d     = REPORT;
                    res_valid_d = 1'b1;
                    res_face_d  = throw;
                    res_error_d = ~throw_ok;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = button ? ROLLING : IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            res_face_q  <= '0;
            res_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= res_valid_d;
            res_face_q  <= res_face_d;
            res_error_q <= res_error_d;
        end
    end

    assign cap_valid = capture & throw_ok;
    assign cap_error = capture & ~throw_ok;

    for (genvar i = FACE_MIN; i <= FACE_MAX; i++) begin : g_face
        sat_counter #(.W(COUNT_W)) u_face_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (count_clr),
            .inc   (cap_valid && (throw == FACE_W'(i))),
            .count (face_cnt[i])
        );
    end

    sat_counter #(.W(COUNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (count_clr),
        .inc   (cap_error),
        .count (err_cnt)
    );

    // Error captures are not rolls, so only valid faces advance the total.
    always_comb begin
        total_d = total_q;
        if (count_clr) begin
            total_d = '0;
        end else if (cap_valid) begin
            total_d = total_q + TOTAL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    always_comb begin
        count_out = '0;
        case (count_sel)
            3'd0: count_out = err_cnt;
            3'd1: count_out = face_cnt[1];
            3'd2: count_out = face_cnt[2];
            3'd3: count_out = face_cnt[3];
            3'd4: count_out = face_cnt[4];
            3'd5: count_out = face_cnt[5];
            3'd6: count_out = face_cnt[6];
            3'd7: count_out = total_q[COUNT_W-1:0];
            default: count_out = '0;
        endcase
    end

    assign res_valid  = res_valid_q;
    assign res_face   = res_face_q;
    assign res_error  = res_error_q;
    assign roll_total = total_q;

endmodule

// File: tb/tb_dice_roll_capture.sv
// Self-checking bench for dice_roll_capture: directed scenarios plus a random
// run, all compared against a behavioural model of the roll/report/statistics rules.
module tb_dice_roll_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic [2:0] throw;
    logic       res_ready;
    logic       res_valid;
    logic [2:0] res_face;
    logic       res_error;
    logic       count_clr;
    logic [2:0] count_sel;
    logic [7:0] count_out;
    logic [9:0] roll_total;

    int checks = 0;
    int errors = 0;

    // Behavioural model: is the player rolling, is a result pending, statistics.
    bit m_rolling;
    bit m_have;
    bit m_err;
    int m_face;
    int m_cnt [7];
    int m_total;

    dice_roll_capture dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .throw      (throw),
        .res_ready  (res_ready),
        .res_valid  (res_valid),
        .res_face   (res_face),
        .res_error  (res_error),
        .count_clr  (count_clr),
        .count_sel  (count_sel),
        .count_out  (count_out),
        .roll_total (roll_total)
    );

    always #10 clk = ~clk;

    function automatic int exp_count(input int sel);
        if (sel == 0) return m_cnt[0];
        if (sel == 7) return m_total % 256;
        return m_cnt[sel];
    endfunction

    task automatic model_edge();
        bit cap;
        int t;
        t = int'(throw);
        if (rst) begin
            m_rolling = 0; m_have = 0; m_face = 0; m_err = 0; m_total = 0;
            for (int k = 0; k < 7; k++) m_cnt[k] = 0;
        end else begin
            cap = m_rolling && !m_have && !button;
            if (count_clr) begin
                for (int k = 0; k < 7; k++) m_cnt[k] = 0;
                m_total = 0;
            end else if (cap) begin
                if (t >= 1 && t <= 6) begin
                    if (m_cnt[t] < 255) m_cnt[t]++;
                    m_total = (m_total + 1) % 1024;
                end else if (m_cnt[0] < 255) begin
                    m_cnt[0]++;
                end
            end
            if (m_have) begin
                if (res_ready) begin
                    m_have = 0;
                    m_rolling = button;
                end
            end else if (m_rolling) begin
                if (!button) begin
                    m_have = 1; m_face = t; m_err = !(t >= 1 && t <= 6); m_rolling = 0;
                end
            end else begin
                m_rolling = button;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Dice generator: tumbles random faces while held, shows 'face' at release.
    task automatic roll(input int hold, input int face);
        button = 1'b1;
        repeat (hold) begin
            throw = 3'($urandom_range(1, 6));
            cycle();
        end
        button = 1'b0;
        throw = 3'(face);
        cycle();
    endtask

    task automatic accept();
        button = 1'b0;
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", res_valid); end
        checks++; if (res_face !== 3'd0) begin errors++; $display("FAIL reset_face: got %0d expected 0", res_face); end
        checks++; if (res_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b expected 0", res_error); end
        checks++; if (roll_total !== 10'd0) begin errors++; $display("FAIL reset_total: got %0d expected 0", roll_total); end
        for (int s = 0; s < 8; s++) begin
            count_sel = 3'(s);
            #1;
            checks++; if (count_out !== 8'd0) begin errors++; $display("FAIL reset_count sel=%0d: got %0d expected 0", s, count_out); end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        roll(4, 4);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", res_valid); end
        checks++; if (res_face !== 3'd4) begin errors++; $display("FAIL basic_face: got %0d expected 4", res_face); end
        checks++; if (res_error !== 1'b0) begin errors++; $display("FAIL basic_error: got %0b expected 0", res_error); end
        count_sel = 3'd4;
        #1;
        checks++; if (count_out !== 8'd1) begin errors++; $display("FAIL basic_count4: got %0d expected 1", count_out); end
        cycle();
        checks++; if (roll_total !== 10'd1) begin errors++; $display("FAIL basic_total: got %0d expected 1", roll_total); end
        accept();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_accept: got %0b expected 0", res_valid); end
    endtask

    task automatic test_backpressure();
        int f, c0, t0;
        f = $urandom_range(1, 6);
        roll(2, f);
        c0 = m_cnt[f];
        t0 = m_total;
        res_ready = 1'b0;
        count_sel = 3'(f);
        repeat (5) begin
            button = 1'($urandom_range(0, 1));
            throw = 3'($urandom_range(0, 7));
            cycle();
            checks++; if (res_valid !== 1'b1 || res_face !== 3'(f)) begin errors++; $display("FAIL bp_hold: got valid=%0b face=%0d expected valid=1 face=%0d", res_valid, res_face, f); end
            checks++; if (count_out !== 8'(c0) || roll_total !== 10'(t0)) begin errors++; $display("FAIL bp_counts: got cnt=%0d total=%0d expected cnt=%0d total=%0d", count_out, roll_total, c0, t0); end
        end
        accept();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_accept: got %0b expected 0", res_valid); end
    endtask

    task automatic test_error();
        int e0, t0;
        e0 = m_cnt[0];
        t0 = m_total;
        roll(3, 7);
        checks++; if (res_valid !== 1'b1 || res_error !== 1'b1) begin errors++; $display("FAIL err_flag: got valid=%0b err=%0b expected 1 1", res_valid, res_error); end
        count_sel = 3'd0;
        #1;
        checks++; if (count_out !== 8'(e0 + 1)) begin errors++; $display("FAIL err_count: got %0d expected %0d", count_out, e0 + 1); end
        checks++; if (roll_total !== 10'(t0)) begin errors++; $display("FAIL err_total: got %0d expected %0d", roll_total, t0); end
        accept();
    endtask

    task automatic test_saturate();
        count_clr = 1'b1;
        cycle();
        count_clr = 1'b0;
        repeat (300) begin
            roll(1, 2);
            accept();
        end
        count_sel = 3'd2;
        #1;
        checks++; if (count_out !== 8'd255) begin errors++; $display("FAIL sat_count2: got %0d expected 255", count_out); end
        checks++; if (roll_total !== 10'd300) begin errors++; $display("FAIL sat_total: got %0d expected 300", roll_total); end
        button = 1'b1;
        cycle();
        button = 1'b0;
        throw = 3'd2;
        count_clr = 1'b1;
        cycle();
        count_clr = 1'b0;
        checks++; if (res_valid !== 1'b1 || res_face !== 3'd2) begin errors++; $display("FAIL clr_capture: got valid=%0b face=%0d expected 1 2", res_valid, res_face); end
        checks++; if (roll_total !== 10'd0) begin errors++; $display("FAIL clr_total: got %0d expected 0", roll_total); end
        for (int s = 0; s < 8; s++) begin
            count_sel = 3'(s);
            #1;
            checks++; if (count_out !== 8'd0) begin errors++; $display("FAIL clr_count sel=%0d: got %0d expected 0", s, count_out); end
        end
        accept();
    endtask

    task automatic test_reset_mid_roll();
        roll(2, 5);
        accept();
        button = 1'b1;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        checks++; if (res_valid !== 1'b0 || roll_total !== 10'd0) begin errors++; $display("FAIL rstroll_state: got valid=%0b total=%0d expected 0 0", res_valid, roll_total); end
        count_sel = 3'd5;
        #1;
        checks++; if (count_out !== 8'd0) begin errors++; $display("FAIL rstroll_count5: got %0d expected 0", count_out); end
        rst = 1'b0;
        cycle();
        button = 1'b0;
        throw = 3'd3;
        cycle();
        checks++; if (res_valid !== 1'b1 || res_face !== 3'd3) begin errors++; $display("FAIL rst_release_roll: got valid=%0b face=%0d expected 1 3", res_valid, res_face); end
        accept();
        roll(1, 6);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        count_sel = 3'd6;
        #1;
        checks++; if (res_valid !== 1'b0 || res_face !== 3'd0 || count_out !== 8'd0) begin errors++; $display("FAIL rstreport: got valid=%0b face=%0d cnt=%0d expected 0 0 0", res_valid, res_face, count_out); end
    endtask

    task automatic test_back_to_back();
        roll(2, 1);
        button = 1'b1;
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept: got %0b expected 0", res_valid); end
        repeat (6) begin
            throw = 3'($urandom_range(1, 6));
            cycle();
        end
        button = 1'b0;
        throw = 3'd6;
        cycle();
        checks++; if (res_valid !== 1'b1 || res_face !== 3'd6) begin errors++; $display("FAIL b2b_second: got valid=%0b face=%0d expected 1 6", res_valid, res_face); end
        // Handshake with button high, release on the very next edge: only works if already rolling.
        button = 1'b1;
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        button = 1'b0;
        throw = 3'd5;
        cycle();
        checks++; if (res_valid !== 1'b1 || res_face !== 3'd5) begin errors++; $display("FAIL b2b_immediate: got valid=%0b face=%0d expected 1 5", res_valid, res_face); end
        accept();
    endtask

    task automatic test_random();
        int sel;
        repeat (600) begin
            rst       = ($urandom_range(0, 99) == 0);
            button    = ($urandom_range(0, 2) != 0);
            res_ready = 1'($urandom_range(0, 1));
            throw     = 3'($urandom_range(0, 7));
            count_clr = ($urandom_range(0, 59) == 0);
            cycle();
            sel = $urandom_range(0, 7);
            count_sel = 3'(sel);
            #1;
            checks++;
            if (res_valid !== 1'(m_have) || res_face !== 3'(m_face) || res_error !== 1'(m_err) || roll_total !== 10'(m_total)) begin
                errors++;
                $display("FAIL rnd_result: got v=%0b f=%0d e=%0b t=%0d expected v=%0b f=%0d e=%0b t=%0d",
                         res_valid, res_face, res_error, roll_total, m_have, m_face, m_err, m_total);
            end
            checks++;
            if (count_out !== 8'(exp_count(sel))) begin
                errors++;
                $display("FAIL rnd_count sel=%0d: got %0d expected %0d", sel, count_out, exp_count(sel));
            end
        end
        rst = 1'b0;
        count_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        button = 1'b0;
        throw = 3'd0;
        res_ready = 1'b0;
        count_clr = 1'b0;
        count_sel = 3'd0;
        test_reset();
        test_basic();
        test_backpressure();
        test_error();
        test_saturate();
        test_reset_mid_roll();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
